// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit
// ---------------------------------------------------------------------------
// Datapath-side fetch/memory unit for the multicycle processor. It holds the
// program counter (PC), the instruction register (IR) and the memory data
// register (MDR). All instruction and data accesses share one req/ready
// memory port. While an access is in flight, Mem_Busy tells the control unit
// to hold its current state.
//
// Requests are launched combinationally from IDLE. While the unit waits for
// mem_ready, the address, write enable and write data come from registered
// copies, so they stay stable until the memory completes.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   When it is defined, a wait counter aborts any access that stays
//   unanswered for TIMEOUT_CYCLES wait cycles. It also sets the sticky
//   bus_error flag. A fetch that is aborted loads a NOP (32'h0) into the IR.
//   When it is undefined, accesses wait indefinitely and bus_error is 0.
//
// Parameters:
//   RESET_PC        PC value after reset
//   TIMEOUT_CYCLES  wait-cycle limit per access (FETCH_TIMEOUT_EN only)
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   PC_Write, PC_Src      PC load enable; source select (0 ALU_Result, 1 ALU_Out)
//   I_or_D                address source (0 PC, 1 ALU_Out)
//   Mem_Write, IR_Write   data write request; instruction fetch request
//   ALU_Result, ALU_Out   combinational / registered ALU results
//   Write_Data            store data
//   mem_rdata, mem_ready  memory read data and completion
//   mem_req, mem_we       memory request and write strobe
//   mem_addr, mem_wdata   request address and write data
//   Mem_Busy              access pending, control unit must hold
//   Op, Funct             Instr[31:26], Instr[5:0]
//   Instr, Data, PC       IR, MDR and program counter contents
//   bus_error             sticky access-timeout flag
// ---------------------------------------------------------------------------
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Write,
    input  logic        PC_Src,
    input  logic        I_or_D,
    input  logic        Mem_Write,
    input  logic        IR_Write,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] ALU_Out,
    input  logic [31:0] Write_Data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        Mem_Busy,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [31:0] Instr,
    output logic [31:0] Data,
    output logic [31:0] PC,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FETCH_WAIT = 2'd1,
        ST_DATA_WAIT  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] data_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic        launch_s;
    logic        complete_s;
    logic        abort_s;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt_r;
    logic        bus_error_r;

    // The abort happens in the cycle where the count of unanswered wait cycles
    // reaches the limit. mem_ready in that same cycle still completes the access.
    assign abort_s = (state_r != ST_IDLE) && !mem_ready && (wait_cnt_r == TIMEOUT_LIMIT);

    // Wait counter: cleared on launch, counts unanswered wait cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 16'd0;
        end else if (launch_s) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_r != ST_IDLE) && !mem_ready && !abort_s) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky bus error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_error_r <= 1'b0;
        end else if (abort_s) begin
            bus_error_r <= 1'b1;
        end else begin
            bus_error_r <= bus_error_r;
        end
    end

    assign bus_error = bus_error_r;
`else
    assign abort_s   = 1'b0;
    assign bus_error = 1'b0;
`endif

    // Next-state and memory-port outputs. The request is launched combinationally from IDLE.
    always_comb begin
        state_next_s = state_r;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = pc_r;
        mem_wdata    = 32'h0000_0000;
        Mem_Busy     = 1'b0;
        launch_s     = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (IR_Write) begin
                    // An instruction fetch has priority over a data access.
                    mem_req      = 1'b1;
                    mem_addr     = pc_r;
                    Mem_Busy     = 1'b1;
                    launch_s     = 1'b1;
                    state_next_s = ST_FETCH_WAIT;
                end else if (I_or_D) begin
                    mem_req      = 1'b1;
                    mem_we       = Mem_Write;
                    mem_addr     = ALU_Out;
                    mem_wdata    = Write_Data;
                    Mem_Busy     = 1'b1;
                    launch_s     = 1'b1;
                    state_next_s = ST_DATA_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH_WAIT, ST_DATA_WAIT: begin
                mem_req   = 1'b1;
                mem_we    = we_r;
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
                if (mem_ready) begin
                    complete_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (abort_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    Mem_Busy = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and request holding registers captured at launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (launch_s) begin
                addr_r  <= mem_addr;
                wdata_r <= mem_wdata;
                we_r    <= mem_we;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                we_r    <= we_r;
            end
        end
    end

    // The PC commits only while no access is pending. On a fetch, it commits in the IR load cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (PC_Write && !Mem_Busy) begin
            pc_r <= PC_Src ? ALU_Out : ALU_Result;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction register: loads on fetch completion, or a NOP on a fetch abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= 32'h0000_0000;
        end else if ((state_r == ST_FETCH_WAIT) && complete_s) begin
            instr_r <= mem_rdata;
        end else if ((state_r == ST_FETCH_WAIT) && abort_s) begin
            instr_r <= 32'h0000_0000;
        end else begin
            instr_r <= instr_r;
        end
    end

    // Memory data register: loads only on completion of a data read.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= 32'h0000_0000;
        end else if ((state_r == ST_DATA_WAIT) && complete_s && !we_r) begin
            data_r <= mem_rdata;
        end else begin
            data_r <= data_r;
        end
    end

    assign PC    = pc_r;
    assign Instr = instr_r;
    assign Data  = data_r;
    assign Op    = instr_r[31:26];
    assign Funct = instr_r[5:0];

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Self-checking bench for fetch_mem_unit: directed scenarios plus randomized
// fetch / load / store / PC-only transactions against a transaction-level model.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_Write, PC_Src, I_or_D, Mem_Write, IR_Write;
    logic [31:0] ALU_Result, ALU_Out, Write_Data, mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, Mem_Busy, bus_error;
    logic [31:0] mem_addr, mem_wdata, Instr, Data, PC;
    logic [5:0]  Op, Funct;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model of the architectural state
    logic [31:0] m_pc, m_instr, m_data;
    logic        m_bus_err;

    always #5 clk = ~clk;

    fetch_mem_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .PC_Write(PC_Write), .PC_Src(PC_Src),
        .I_or_D(I_or_D), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .ALU_Result(ALU_Result), .ALU_Out(ALU_Out), .Write_Data(Write_Data),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .Mem_Busy(Mem_Busy), .Op(Op), .Funct(Funct), .Instr(Instr),
        .Data(Data), .PC(PC), .bus_error(bus_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        IR_Write  = 1'b0;
        I_or_D    = 1'b0;
        Mem_Write = 1'b0;
        PC_Write  = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_instr"}, Instr, m_instr);
        check({tag, "_op"}, {26'd0, Op}, {26'd0, m_instr[31:26]});
        check({tag, "_funct"}, {26'd0, Funct}, {26'd0, m_instr[5:0]});
        check({tag, "_data"}, Data, m_data);
        check({tag, "_pc"}, PC, m_pc);
        check({tag, "_buserr"}, {31'd0, bus_error}, {31'd0, m_bus_err});
        check({tag, "_req_idle"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, Mem_Busy}, 32'd0);
    endtask

    // Instruction fetch with memory answering on wait cycle 'lat'.
    task automatic do_fetch(input int lat, input logic [31:0] rdata, input logic pcw,
                            input logic pcs, input logic [31:0] ar, input logic [31:0] ao);
        logic [31:0] addr;
        addr = m_pc;
        @(negedge clk);
        IR_Write = 1'b1; I_or_D = 1'($urandom_range(0, 1)); Mem_Write = 1'($urandom_range(0, 1));
        PC_Write = pcw; PC_Src = pcs; ALU_Result = ar; ALU_Out = ao; Write_Data = $urandom;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        check("f_launch_req", {31'd0, mem_req}, 32'd1);
        check("f_launch_we", {31'd0, mem_we}, 32'd0);
        check("f_launch_addr", mem_addr, addr);
        check("f_launch_busy", {31'd0, Mem_Busy}, 32'd1);
        for (int w = 1; w <= lat; w++) begin
            @(negedge clk);
            mem_ready  = (w == lat);
            mem_rdata  = (w == lat) ? rdata : $urandom;
            I_or_D     = 1'($urandom_range(0, 1));
            Mem_Write  = 1'($urandom_range(0, 1));
            Write_Data = $urandom;
            #1;
            check("f_wait_req", {31'd0, mem_req}, 32'd1);
            check("f_wait_addr", mem_addr, addr);
            check("f_wait_we", {31'd0, mem_we}, 32'd0);
            check("f_wait_busy", {31'd0, Mem_Busy}, (w == lat) ? 32'd0 : 32'd1);
        end
        m_instr = rdata;
        if (pcw) m_pc = pcs ? ao : ar;
        @(negedge clk);
        drive_idle();
        #1;
        check_regs("fetch");
    endtask

    // Data access; ALU_Out doubles as the address and as a PC source.
    task automatic do_data(input int lat, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input logic pcw, input logic pcs, input logic [31:0] ar);
        @(negedge clk);
        IR_Write = 1'b0; I_or_D = 1'b1; Mem_Write = we; ALU_Out = addr; Write_Data = wd;
        PC_Write = pcw; PC_Src = pcs; ALU_Result = ar;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        check("d_launch_req", {31'd0, mem_req}, 32'd1);
        check("d_launch_we", {31'd0, mem_we}, {31'd0, we});
        check("d_launch_addr", mem_addr, addr);
        check("d_launch_wdata", mem_wdata, wd);
        check("d_launch_busy", {31'd0, Mem_Busy}, 32'd1);
        for (int w = 1; w <= lat; w++) begin
            @(negedge clk);
            mem_ready  = (w == lat);
            mem_rdata  = (w == lat) ? rdata : $urandom;
            IR_Write   = 1'($urandom_range(0, 1));
            Mem_Write  = 1'($urandom_range(0, 1));
            Write_Data = $urandom;
            #1;
            check("d_wait_req", {31'd0, mem_req}, 32'd1);
            check("d_wait_addr", mem_addr, addr);
            check("d_wait_we", {31'd0, mem_we}, {31'd0, we});
            check("d_wait_wdata", mem_wdata, wd);
            check("d_wait_busy", {31'd0, Mem_Busy}, (w == lat) ? 32'd0 : 32'd1);
        end
        if (!we) m_data = rdata;
        if (pcw) m_pc = pcs ? addr : ar;
        @(negedge clk);
        drive_idle();
        #1;
        check_regs(we ? "store" : "load");
    endtask

    // PC update with no memory access. mem_ready in IDLE must be ignored.
    task automatic do_pc_only(input logic pcs, input logic [31:0] ar, input logic [31:0] ao);
        @(negedge clk);
        IR_Write = 1'b0; I_or_D = 1'b0; PC_Write = 1'b1; PC_Src = pcs;
        ALU_Result = ar; ALU_Out = ao; mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        check("pc_req", {31'd0, mem_req}, 32'd0);
        check("pc_busy", {31'd0, Mem_Busy}, 32'd0);
        m_pc = pcs ? ao : ar;
        @(negedge clk);
        drive_idle();
        #1;
        check_regs("pconly");
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_data = 32'h0; m_bus_err = 1'b0;
        #1;
        check_regs("reset");
    endtask

`ifdef FETCH_TIMEOUT_EN
    // Access never answered: busy for TIMEOUT_CYCLES wait cycles, then an abort cycle.
    task automatic do_timeout(input logic is_fetch);
        @(negedge clk);
        IR_Write = is_fetch; I_or_D = 1'b1; Mem_Write = 1'b0; PC_Write = 1'b0;
        ALU_Out = 32'h80; mem_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check("to_busy", {31'd0, Mem_Busy}, (w == 5) ? 32'd0 : 32'd1);
        end
        if (is_fetch) m_instr = 32'h0;
        m_bus_err = 1'b1;
        @(negedge clk);
        drive_idle();
        #1;
        check_regs("timeout");
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        PC_Src = 1'b0; ALU_Result = 32'h0; ALU_Out = 32'h0; Write_Data = 32'h0; mem_rdata = 32'h0;
        apply_reset();

        // Fetch of addi with a 2-cycle latency, PC <- 4
        do_fetch(2, 32'h2008_0005, 1'b1, 1'b0, 32'd4, $urandom);
        check("t2_instr", Instr, 32'h2008_0005);
        check("t2_op", {26'd0, Op}, 32'd8);
        check("t2_pc", PC, 32'd4);

        // R-type add fetched from PC=4
        do_fetch(1, 32'h0109_5020, 1'b0, 1'b0, $urandom, $urandom);
        check("t3_op", {26'd0, Op}, 32'd0);
        check("t3_funct", {26'd0, Funct}, 32'd32);

        // Load, then store (Data must not change on the store)
        do_data(2, 1'b0, 32'h40, $urandom, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check("t4_load", Data, 32'hDEAD_BEEF);
        do_data(1, 1'b1, 32'h44, 32'h1234, $urandom, 1'b0, 1'b0, 32'h0);
        check("t4_store", Data, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: do_fetch($urandom_range(1, 5), $urandom, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom, $urandom);
                1: do_data($urandom_range(1, 5), 1'b0, $urandom, $urandom, $urandom,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                2: do_data($urandom_range(1, 5), 1'b1, $urandom, $urandom, $urandom,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                default: do_pc_only(1'($urandom_range(0, 1)), $urandom, $urandom);
            endcase
        end

        // Reset while in FETCH_WAIT; a late mem_ready must be ignored
        @(negedge clk);
        IR_Write = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1; PC_Write = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        m_pc = 32'h0; m_instr = 32'h0; m_data = 32'h0; m_bus_err = 1'b0;
        #1;
        check("t5_req", {31'd0, mem_req}, 32'd0);
        check("t5_busy", {31'd0, Mem_Busy}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_regs("t5");

`ifdef FETCH_TIMEOUT_EN
        do_fetch(1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 32'h0);
        do_timeout(1'b1);
        do_data(1, 1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        do_timeout(1'b0);
        do_fetch(5, 32'h3333_4444, 1'b1, 1'b0, 32'h8, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
Datapath-side counterpart of the multicycle control unit. It consumes PC_Write, I_or_D, Mem_Write, IR_Write and PC_Src. It produces Op and Funct back to the control unit, and holds the PC, instruction register (IR) and memory data register (MDR). All instruction and data accesses go through one req/ready memory port. Mem_Busy tells the control unit to hold its current state until the access completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT_CYCLES, 16, wait-cycle limit per access (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
PC_Write  in  1  load PC (from control unit)
PC_Src  in  1  PC source: 0 = ALU_Result, 1 = ALU_Out
I_or_D  in  1  address source: 0 = PC, 1 = ALU_Out
Mem_Write  in  1  data access is a write
IR_Write  in  1  fetch instruction into IR
ALU_Result  in  32  combinational ALU result
ALU_Out  in  32  registered ALU result
Write_Data  in  32  store data (B register)
mem_rdata  in  32  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes the current request
mem_req  out  1  memory request
mem_we  out  1  write request
mem_addr  out  32  request address
mem_wdata  out  32  write data
Mem_Busy  out  1  access pending; control unit holds its state
Op  out  6  Instr[31:26]
Funct  out  6  Instr[5:0]
Instr  out  32  IR contents
Data  out  32  MDR contents
PC  out  32  program counter
bus_error  out  1  sticky timeout flag (FETCH_TIMEOUT_EN only, else constant 0)

Behaviour:
- Reset values: PC=RESET_PC; Instr=0, so Op=0 and Funct=0; Data=0; mem_req=0; mem_we=0; Mem_Busy=0; bus_error=0; state=IDLE.
- States: IDLE, FETCH_WAIT, DATA_WAIT.
- IDLE, IR_Write=1:
  - mem_req=1, mem_we=0, mem_addr=PC. I_or_D is ignored; IR_Write has priority.
  - Next state FETCH_WAIT.
- IDLE, IR_Write=0, I_or_D=1:
  - mem_req=1, mem_addr=ALU_Out, mem_we=Mem_Write, mem_wdata=Write_Data.
  - Next state DATA_WAIT.
- IDLE, neither condition: mem_req=0; state stays IDLE.
- Request handshake:
  - The request is launched combinationally in IDLE.
  - While waiting, mem_req stays 1 and addr/we/wdata are registered copies that stay stable until mem_ready.
  - mem_ready is sampled only in the WAIT states, so minimum access latency is 1 cycle after launch. mem_ready in IDLE is ignored.
- Mem_Busy (combinational):
  - 1 in IDLE when a request launches.
  - 1 in a WAIT state while mem_ready=0.
  - 0 otherwise.
- FETCH_WAIT with mem_ready=1: Instr <= mem_rdata; next state IDLE.
- DATA_WAIT with mem_ready=1: on a read, Data <= mem_rdata; on a write, Data is unchanged. Next state IDLE.
- PC update:
  - Condition: PC_Write=1 and Mem_Busy=0.
  - Value: PC <= PC_Src ? ALU_Out : ALU_Result.
  - During a fetch, PC therefore commits in the same cycle the IR loads.
- Op and Funct reflect the new IR one cycle after the mem_ready edge.
- reset=1 mid-access: state returns to IDLE next edge; mem_req drops; any in-flight mem_ready and rdata are ignored; no register loads.
- Control-input changes during a WAIT state are ignored. The control unit must hold them stable while Mem_Busy=1.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8..16-bit wait counter clears on every request launch and increments each WAIT cycle with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES, the access is aborted: state -> IDLE, mem_req drops, bus_error sets (sticky until reset), and Mem_Busy=0 in that abort cycle.
  - A fetch abort loads Instr=32'h0000_0000, i.e. a NOP (sll $0). A data abort leaves Data unchanged.
  - mem_ready arriving in the abort cycle wins: the access completes normally, no error.
- Undefined: no counter; waits indefinitely; bus_error tied to 0.

Test Plan:
1. Reset:
   - Stimulus: reset=1 for 2 cycles, then release.
   - Required: PC=0, Op=0, Funct=0, mem_req=0, Mem_Busy=0.
2. Instruction fetch with 2-cycle latency:
   - Stimulus: IR_Write=1, PC_Write=1, PC_Src=0, ALU_Result=4; mem_ready on the 2nd wait cycle with mem_rdata=32'h2008_0005 (addi).
   - Required: mem_addr=0 throughout; Mem_Busy high for 2 cycles; then Instr=32'h2008_0005, Op=6'b001000, PC=4.
3. R-type fetch:
   - Stimulus: fetch 32'h0109_5020 (add) at PC=4.
   - Required: Op=0, Funct=6'b100000.
4. Data load then store:
   - Load stimulus: I_or_D=1, ALU_Out=32'h40, Mem_Write=0, rdata=32'hDEAD_BEEF. Required: Data=32'hDEAD_BEEF.
   - Store stimulus: Mem_Write=1, Write_Data=32'h1234. Required: mem_we=1, mem_wdata=32'h1234, Data unchanged.
5. Reset mid-fetch:
   - Stimulus: assert reset in FETCH_WAIT, then drive mem_ready=1 the following cycle.
   - Required: Instr stays 0; state IDLE; mem_req=0.
6. FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4:
   - Stimulus: fetch with mem_ready held 0.
   - Required: abort after 4 wait cycles; bus_error=1; Instr=0; Mem_Busy=0.
